// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit scanning from ptr upward, modulo N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] sel,
    output logic           any
);

    logic [IDW:0] idx;

    // Scan from farthest to nearest so the closest request to ptr wins.
    always_comb begin
        sel = '0;
        idx = '0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (IDW + 1)'(ptr) + (IDW + 1)'(k);
            if (idx >= (IDW + 1)'(N)) begin
                idx = idx - (IDW + 1)'(N);
            end
            if (req[idx[IDW-1:0]]) begin
                sel = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one fifo write port among N producers with round-robin selection and
// packet locking, so packets are never interleaved and full is never overrun.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 32,
    localparam int IDW   = $clog2(N)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic                 fifo_wr_en,
    output logic [WIDTH-1:0]     fifo_wr_data,
    input  logic                 fifo_full,
    output logic [IDW-1:0]       grant_id,
    output logic                 grant_vld,
    output logic                 locked,
    output logic [PKT_CNT_W-1:0] pkt_count
);

    // Handshake: a beat transfers in the cycle where in_valid[i] and in_ready[i]
    // are both high. in_ready may look at every in_valid; producers must hold
    // in_valid and data stable until accepted and never derive valid from ready.

    arb_state_t           st, st_nxt;
    logic [IDW-1:0]       owner, owner_nxt;
    logic [IDW-1:0]       rr_ptr, rr_ptr_nxt;
    logic [PKT_CNT_W-1:0] pkt_nxt;
    logic [IDW-1:0]       pick_sel, sel, sel_inc;
    logic                 pick_any, acc;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req (in_valid),
        .ptr (rr_ptr),
        .sel (pick_sel),
        .any (pick_any)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st        <= ARB_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            pkt_count <= '0;
        end else begin
            st        <= st_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            pkt_count <= pkt_nxt;
        end
    end

    // Outputs are held quiet while reset is asserted, whatever the inputs do.
    always_comb begin
        sel          = (st == ARB_LOCKED) ? owner : pick_sel;
        grant_vld    = !reset && ((st == ARB_LOCKED) ? in_valid[owner] : pick_any);
        grant_id     = reset ? '0 : sel;
        locked       = (st == ARB_LOCKED);
        acc          = grant_vld && !fifo_full;
        fifo_wr_en   = acc;
        fifo_wr_data = grant_vld ? in_data[int'(sel) * WIDTH +: WIDTH] : '0;
        in_ready     = '0;
        for (int i = 0; i < N; i++) begin
            if (acc && (sel == IDW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
        sel_inc = (sel == IDW'(N - 1)) ? '0 : sel + IDW'(1);

        st_nxt     = st;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        pkt_nxt    = pkt_count;
        if (acc) begin
            if (in_last[sel]) begin
                st_nxt     = ARB_IDLE;
                rr_ptr_nxt = sel_inc;
                pkt_nxt    = pkt_count + 1'b1;
            end else begin
                st_nxt    = ARB_LOCKED;
                owner_nxt = sel;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N=4, WIDTH=32) with hand-computed expectations.
module tb_fifo_wr_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_last;
    logic [3:0]   in_ready;
    logic         fifo_wr_en;
    logic [31:0]  fifo_wr_data;
    logic         fifo_full;
    logic [1:0]   grant_id;
    logic         grant_vld;
    logic         locked;
    logic [15:0]  pkt_count;

    int errors = 0;
    int checks = 0;
    int writes;

    // {grant_vld, grant_id, locked, fifo_wr_en, in_ready}
    logic [8:0] obs;
    assign obs = {grant_vld, grant_id, locked, fifo_wr_en, in_ready};

    fifo_wr_arbiter #(.N(4), .WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .grant_vld    (grant_vld),
        .locked       (locked),
        .pkt_count    (pkt_count)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    task automatic set_data(input int i, input logic [31:0] d);
        in_data[i*32 +: 32] = d;
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f);
        @(negedge clock);
        in_valid  = v;
        in_last   = l;
        fifo_full = f;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        #1;
        checks++;
        if (obs !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", obs, 9'b0);
        end
        checks++;
        if (pkt_count !== 16'd0 || fifo_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_count_data: got %h/%h want 0000/00000000", pkt_count, fifo_wr_data);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single_beat();
        drive(4'b0100, 4'b0100, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd2, 1'b0, 1'b1, 4'b0100} || fifo_wr_data !== 32'hA5A5_0002) begin
            errors++;
            $display("FAIL single_beat: got %b/%h want %b/%h", obs, fifo_wr_data,
                     {1'b1, 2'd2, 1'b0, 1'b1, 4'b0100}, 32'hA5A5_0002);
        end
        // rr_ptr is now 3, so req 3 beats req 2.
        drive(4'b1100, 4'b1100, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd3, 1'b0, 1'b1, 4'b1000} || pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL single_ptr3: got %b cnt=%0d want %b cnt=1", obs, pkt_count,
                     {1'b1, 2'd3, 1'b0, 1'b1, 4'b1000});
        end
        drive(4'b0000, 4'b0000, 1'b0);
        checks++;
        if (obs !== 9'b0 || pkt_count !== 16'd2 || fifo_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL single_idle: got %b cnt=%0d data=%h want 0 cnt=2 data=0", obs, pkt_count, fifo_wr_data);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        logic [3:0] r;
        writes = 0;
        for (int k = 0; k < 8; k++) begin
            g = 2'(k % 4);
            r = 4'b0001 << g;
            drive(4'b1111, 4'b1111, 1'b0);
            if (fifo_wr_en === 1'b1) writes++;
            checks++;
            if (obs !== {1'b1, g, 1'b0, 1'b1, r} || fifo_wr_data !== (32'hA5A5_0000 + 32'(g))) begin
                errors++;
                $display("FAIL rr_cycle%0d: got %b/%h want %b/%h", k, obs, fifo_wr_data,
                         {1'b1, g, 1'b0, 1'b1, r}, 32'hA5A5_0000 + 32'(g));
            end
        end
        drive(4'b0000, 4'b0000, 1'b0);
        checks++;
        if (pkt_count !== 16'd10 || writes !== 8) begin
            errors++;
            $display("FAIL rr_totals: got cnt=%0d writes=%0d want cnt=10 writes=8", pkt_count, writes);
        end
    endtask

    task automatic test_packet_lock();
        drive(4'b0001, 4'b0001, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd0, 1'b0, 1'b1, 4'b0001}) begin
            errors++;
            $display("FAIL lock_setup: got %b want %b", obs, {1'b1, 2'd0, 1'b0, 1'b1, 4'b0001});
        end
        // rr_ptr=1: req 1 starts a 3-beat packet while 0 and 3 wait.
        for (int b = 1; b <= 3; b++) begin
            set_data(1, 32'hB1B1_0000 + 32'(b));
            drive(4'b1011, (b == 3) ? 4'b1011 : 4'b1001, 1'b0);
            checks++;
            if (obs !== {1'b1, 2'd1, (b != 1), 1'b1, 4'b0010} || fifo_wr_data !== (32'hB1B1_0000 + 32'(b))) begin
                errors++;
                $display("FAIL lock_beat%0d: got %b/%h want %b/%h", b, obs, fifo_wr_data,
                         {1'b1, 2'd1, (b != 1), 1'b1, 4'b0010}, 32'hB1B1_0000 + 32'(b));
            end
        end
        set_data(1, 32'hA5A5_0001);
        drive(4'b1001, 4'b1001, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd3, 1'b0, 1'b1, 4'b1000} || pkt_count !== 16'd12) begin
            errors++;
            $display("FAIL lock_next_grant: got %b cnt=%0d want %b cnt=12", obs, pkt_count,
                     {1'b1, 2'd3, 1'b0, 1'b1, 4'b1000});
        end
        drive(4'b0001, 4'b0001, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd0, 1'b0, 1'b1, 4'b0001} || pkt_count !== 16'd13) begin
            errors++;
            $display("FAIL lock_wrap_to0: got %b cnt=%0d want %b cnt=13", obs, pkt_count,
                     {1'b1, 2'd0, 1'b0, 1'b1, 4'b0001});
        end
    endtask

    task automatic test_full_backpressure();
        drive(4'b0001, 4'b0000, 1'b1);
        checks++;
        if (obs !== {1'b1, 2'd0, 1'b0, 1'b0, 4'b0000} || fifo_wr_data !== 32'hA5A5_0000) begin
            errors++;
            $display("FAIL full_idle: got %b/%h want %b/a5a50000", obs, fifo_wr_data,
                     {1'b1, 2'd0, 1'b0, 1'b0, 4'b0000});
        end
        drive(4'b0001, 4'b0000, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd0, 1'b0, 1'b1, 4'b0001} || pkt_count !== 16'd14) begin
            errors++;
            $display("FAIL full_first_beat: got %b cnt=%0d want %b cnt=14", obs, pkt_count,
                     {1'b1, 2'd0, 1'b0, 1'b1, 4'b0001});
        end
        set_data(0, 32'hC0C0_0002);
        for (int c = 0; c < 5; c++) begin
            drive(4'b0101, 4'b0101, 1'b1);
            checks++;
            if (obs !== {1'b1, 2'd0, 1'b1, 1'b0, 4'b0000} || pkt_count !== 16'd14 ||
                fifo_wr_data !== 32'hC0C0_0002) begin
                errors++;
                $display("FAIL full_stall%0d: got %b cnt=%0d data=%h want %b cnt=14 data=c0c00002", c, obs,
                         pkt_count, fifo_wr_data, {1'b1, 2'd0, 1'b1, 1'b0, 4'b0000});
            end
        end
        drive(4'b0101, 4'b0101, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd0, 1'b1, 1'b1, 4'b0001} || fifo_wr_data !== 32'hC0C0_0002) begin
            errors++;
            $display("FAIL full_resume: got %b/%h want %b/c0c00002", obs, fifo_wr_data,
                     {1'b1, 2'd0, 1'b1, 1'b1, 4'b0001});
        end
        set_data(0, 32'hA5A5_0000);
        drive(4'b0000, 4'b0000, 1'b0);
        checks++;
        if (obs !== 9'b0 || pkt_count !== 16'd15) begin
            errors++;
            $display("FAIL full_done: got %b cnt=%0d want 0 cnt=15", obs, pkt_count);
        end
    endtask

    task automatic test_owner_stall();
        drive(4'b0001, 4'b0000, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd0, 1'b0, 1'b1, 4'b0001}) begin
            errors++;
            $display("FAIL stall_start: got %b want %b", obs, {1'b1, 2'd0, 1'b0, 1'b1, 4'b0001});
        end
        for (int c = 0; c < 4; c++) begin
            drive(4'b0010, 4'b0010, 1'b0);
            checks++;
            if (obs !== {1'b0, 2'd0, 1'b1, 1'b0, 4'b0000} || fifo_wr_data !== 32'd0) begin
                errors++;
                $display("FAIL stall_block%0d: got %b/%h want %b/00000000", c, obs, fifo_wr_data,
                         {1'b0, 2'd0, 1'b1, 1'b0, 4'b0000});
            end
        end
        drive(4'b0011, 4'b0011, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd0, 1'b1, 1'b1, 4'b0001} || pkt_count !== 16'd15) begin
            errors++;
            $display("FAIL stall_finish: got %b cnt=%0d want %b cnt=15", obs, pkt_count,
                     {1'b1, 2'd0, 1'b1, 1'b1, 4'b0001});
        end
        drive(4'b0010, 4'b0010, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd1, 1'b0, 1'b1, 4'b0010} || pkt_count !== 16'd16) begin
            errors++;
            $display("FAIL stall_other: got %b cnt=%0d want %b cnt=16", obs, pkt_count,
                     {1'b1, 2'd1, 1'b0, 1'b1, 4'b0010});
        end
    endtask

    task automatic test_reset_mid_packet();
        drive(4'b0100, 4'b0000, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd2, 1'b0, 1'b1, 4'b0100} || pkt_count !== 16'd17) begin
            errors++;
            $display("FAIL rst_setup: got %b cnt=%0d want %b cnt=17", obs, pkt_count,
                     {1'b1, 2'd2, 1'b0, 1'b1, 4'b0100});
        end
        drive(4'b0100, 4'b0000, 1'b1);
        checks++;
        if (locked !== 1'b1 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL rst_locked: got locked=%b id=%0d want locked=1 id=2", locked, grant_id);
        end
        // Reset applied between clock edges must act at once.
        in_valid = 4'b0000;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (locked !== 1'b0 || pkt_count !== 16'd0 || obs !== 9'b0) begin
            errors++;
            $display("FAIL rst_async: got locked=%b cnt=%0d obs=%b want 0 0 0", locked, pkt_count, obs);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(4'b0101, 4'b0101, 1'b0);
        checks++;
        if (obs !== {1'b1, 2'd0, 1'b0, 1'b1, 4'b0001}) begin
            errors++;
            $display("FAIL rst_regrant: got %b want %b", obs, {1'b1, 2'd0, 1'b0, 1'b1, 4'b0001});
        end
    endtask

    task automatic test_pkt_wrap();
        writes = 0;
        for (int k = 0; k < 65534; k++) begin
            drive(4'b1111, 4'b1111, 1'b0);
            if (fifo_wr_en === 1'b1) writes++;
        end
        drive(4'b1111, 4'b1111, 1'b0);
        checks++;
        if (pkt_count !== 16'hFFFF || writes !== 65534) begin
            errors++;
            $display("FAIL wrap_max: got cnt=%h writes=%0d want cnt=ffff writes=65534", pkt_count, writes);
        end
        drive(4'b0000, 4'b0000, 1'b0);
        checks++;
        if (pkt_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: got cnt=%h want cnt=0000", pkt_count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        fifo_full = 1'b0;
        in_data   = '0;
        for (int i = 0; i < 4; i++) set_data(i, 32'hA5A5_0000 + 32'(i));
        repeat (2) @(posedge clock);
        test_reset();
        test_single_beat();
        test_round_robin();
        test_packet_lock();
        test_full_backpressure();
        test_owner_stall();
        test_reset_mid_packet();
        test_pkt_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
